pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised elastic pipeline stage register that replaces fixed-field stage registers (ID/EX, EX/MEM, MEM/WB) across the miniRV pipeline.
- Carries a generic data bus and a generic control bus under a valid/ready handshake.
- Uses an internal 2-entry skid buffer, so full throughput is held with a registered in_ready_o.
- Adds flush (branch/jump kill), backpressure stall and bubble tracking with control gating.

Parameters:
- DATA_W, 128: width of the data payload (e.g. rD1/rD2/pc4/pcimm/imm concatenated).
- CTRL_W, 16: width of the control payload (alu_op, wb_sel, rf_we, dram_we, ...).
- CTRL_RST, {CTRL_W{1'b0}}: control value at reset and on bubbles.
- GATE_CTRL, 1: when 1, out_ctrl_o is forced to CTRL_RST whenever out_valid_o=0.
- CNT_W, 32: perf counter width (optional feature only).

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  kill all held entries this cycle.
- in_valid_i  in  1  upstream holds a valid entry.
- in_ready_o  out  1  stage can accept an entry.
- in_data_i  in  DATA_W  upstream data payload.
- in_ctrl_i  in  CTRL_W  upstream control payload.
- out_valid_o  out  1  main register holds a valid entry.
- out_ready_i  in  1  downstream accepts this cycle.
- out_data_o  out  DATA_W  main register data.
- out_ctrl_o  out  CTRL_W  main register control, gated per GATE_CTRL.
- out_null_o  out  1  bubble flag, equal to ~out_valid_o.

Behaviour:
- State:
  - Main entry M (m_v, m_data, m_ctrl).
  - Skid entry S (s_v, s_data, s_ctrl).
- Reset (async, rst_i=1):
  - m_v=0, s_v=0; data registers 0; control registers CTRL_RST.
  - Outputs: out_valid_o=0, out_null_o=1, out_data_o=0, out_ctrl_o=CTRL_RST, in_ready_o=1.
  - Asserting reset mid-transfer drops all entries immediately; no partial output.
- Handshake signals:
  - in_ready_o = ~s_v. It is a registered state bit and is independent of out_ready_i in the same cycle.
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
- Update priority each posedge:
  1. flush_i=1: m_v<=0, s_v<=0. Any in_fire in that cycle is accepted and discarded. Data registers are don't-care; control registers load CTRL_RST.
  2. Otherwise, if m_v=0 or out_ready_i=1 (M free or draining):
     - If s_v=1: M<=S, s_v<=0.
     - Else: M<=in payload, m_v<=in_fire.
  3. Otherwise (M full and stalled) with in_fire: S<=in payload, s_v<=1.
- Latency: 1 cycle from in_fire to out_valid_o when empty.
- Throughput: 1 entry/cycle with out_ready_i held high.
- Ordering: strict FIFO order. No entry is duplicated or lost except on flush.
- Full condition: s_v=1 gives in_ready_o=0. in_valid_i is ignored and upstream must hold its payload.
- Stability: while out_valid_o=1 and out_ready_i=0, out_data_o and out_ctrl_o are stable.
- GATE_CTRL=1: out_ctrl_o = m_v ? m_ctrl : CTRL_RST. This guarantees rf_we/dram_we are 0 on bubbles.
- GATE_CTRL=0: out_ctrl_o = m_ctrl.
- Output gating: out_data_o is never gated.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- When defined, adds two outputs:
  - stall_cnt_o (CNT_W): increments each cycle with out_valid_o=1 and out_ready_i=0.
  - bubble_cnt_o (CNT_W): increments each cycle with out_valid_o=0.
- Both counters saturate at all-ones, reset to 0 on rst_i, and are unaffected by flush_i.
- When undefined, these ports and their logic are absent, and pipeline behaviour is identical.

Test Plan:
- Reset: assert rst_i with in_valid_i=1 -> out_valid_o=0, out_null_o=1, out_ctrl_o=CTRL_RST, in_ready_o=1, asynchronously before the next edge.
- Streaming: out_ready_i=1, feed data 1..8 back-to-back -> outputs appear 1..8 one cycle later on consecutive cycles; in_ready_o stays 1.
- Backpressure: out_ready_i=0 while feeding A, B, C -> M=A, S=B, in_ready_o=0, C held upstream. Raise out_ready_i -> output order A, B, C with no loss.
- Flush: M=A, S=B, flush_i=1 with in_valid_i=1 (D) -> next cycle out_valid_o=0, in_ready_o=1, D never appears.
- Bubble gating: GATE_CTRL=1, in_ctrl_i=16'hFFFF, in_valid_i=0 -> out_ctrl_o=16'h0000, out_null_o=1.
- Perf (PIPE_STAGE_PERF_EN): 3 stalled cycles plus 2 empty cycles after reset -> stall_cnt_o=3, bubble_cnt_o>=2. Force counters near all-ones -> they hold at all-ones.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: main entry plus one skid entry under valid/ready.
// Optional stall/bubble perf counters are compiled in with `define PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int              DATA_W    = 128,
    parameter int              CTRL_W    = 16,
    parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}},
    parameter bit              GATE_CTRL = 1'b1,
    parameter int              CNT_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
`ifdef PIPE_STAGE_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
`endif
    output logic              out_null_o
);

    logic              m_v_q, m_v_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic              s_v_q, s_v_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic              in_fire;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    assign in_ready_o  = ~s_v_q;
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_valid_o = m_v_q;
    assign out_null_o  = ~m_v_q;
    assign out_data_o  = m_data_q;

    if (GATE_CTRL) begin : g_gate_ctrl
        assign out_ctrl_o = m_v_q ? m_ctrl_q : CTRL_RST;
    end else begin : g_raw_ctrl
        assign out_ctrl_o = m_ctrl_q;
    end

    always_comb begin
        m_v_d    = m_v_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_v_d    = s_v_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;
        if (flush_i) begin
            m_v_d    = 1'b0;
            s_v_d    = 1'b0;
            m_ctrl_d = CTRL_RST;
            s_ctrl_d = CTRL_RST;
        end else if (!m_v_q || out_ready_i) begin
            if (s_v_q) begin
                m_v_d    = 1'b1;
                m_data_d = s_data_q;
                m_ctrl_d = s_ctrl_q;
                s_v_d    = 1'b0;
            end else begin
                // Payload loads even without a fire; only m_v qualifies it.
                m_v_d    = in_fire;
                m_data_d = in_data_i;
                m_ctrl_d = in_ctrl_i;
            end
        end else if (in_fire) begin
            s_v_d    = 1'b1;
            s_data_d = in_data_i;
            s_ctrl_d = in_ctrl_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_v_q    <= 1'b0;
            m_data_q <= '0;
            m_ctrl_q <= CTRL_RST;
            s_v_q    <= 1'b0;
            s_data_q <= '0;
            s_ctrl_q <= CTRL_RST;
        end else begin
            m_v_q    <= m_v_d;
            m_data_q <= m_data_d;
            m_ctrl_q <= m_ctrl_d;
            s_v_q    <= s_v_d;
            s_data_q <= s_data_d;
            s_ctrl_q <= s_ctrl_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating counters; flush does not touch them.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (m_v_q && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (!m_v_q && (bubble_cnt_q != {CNT_W{1'b1}}))
            bubble_cnt_d = bubble_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: driver pushes accepted payloads, monitor pops on output fire.
module tb_pipe_stage_reg;
    localparam int DW = 128;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_i, flush_i, in_valid_i, out_ready_i;
    logic          in_ready_o, out_valid_o, out_null_o;
    logic [DW-1:0] in_data_i, out_data_o;
    logic [CW-1:0] in_ctrl_i, out_ctrl_o;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   stall_cnt_o, bubble_cnt_o;
`endif

    pipe_stage_reg dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_ctrl_i   (in_ctrl_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_ctrl_o  (out_ctrl_o),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cnt_o (stall_cnt_o),
        .bubble_cnt_o(bubble_cnt_o),
`endif
        .out_null_o  (out_null_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } item_t;

    item_t exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic logic [DW-1:0] mk_data(int v);
        logic [31:0] w;
        w = 32'(v);
        return {32'hDEAD0000 | w, 64'h0123_4567_89AB_CDEF, w};
    endfunction

    function automatic logic [CW-1:0] mk_ctrl(int v);
        return 16'h8000 | 16'(v);
    endfunction

    // Monitor: one line per output transaction
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            if (!rst_i && !flush_i && out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 128'(out_data_o), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    $display("out: data=%h ctrl=%h", out_data_o, out_ctrl_o);
                    chk("out_data", 128'(out_data_o), 128'(e.d));
                    chk("out_ctrl", 128'(out_ctrl_o), 128'(e.c));
                end
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the posedge that accepted the entry.
    task automatic send(int v, bit must_ready);
        bit done;
        done = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = mk_data(v);
        in_ctrl_i  = mk_ctrl(v);
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (must_ready && t == 0) chk("in_ready_on_send", 128'(in_ready_o), 128'(1));
            if (in_ready_o) begin
                exp_q.push_back({mk_data(v), mk_ctrl(v)});
                $display("in : v=%0d data=%h", v, mk_data(v));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: v=%0d never accepted, got in_ready=0 expected 1", v);
        end
    endtask

    task automatic idle(int n);
        in_valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = mk_data(99); in_ctrl_i = 16'hFFFF;
        #1;
        chk("rst_out_valid", 128'(out_valid_o), 128'(0));
        chk("rst_out_null",  128'(out_null_o),  128'(1));
        chk("rst_out_ctrl",  128'(out_ctrl_o),  128'(0));
        chk("rst_in_ready",  128'(in_ready_o),  128'(1));
        chk("rst_out_data",  128'(out_data_o),  128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0; in_valid_i = 1'b0;

        // Streaming 1..8, one-cycle latency, full throughput
        out_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send(i, 1'b1);
            chk("stream_out_valid", 128'(out_valid_o), 128'(1));
            chk("stream_out_data",  128'(out_data_o),  128'(mk_data(i)));
        end
        idle(2);
        chk("stream_drained", 128'(out_valid_o), 128'(0));

        // Backpressure: A in M, B in S, C held upstream
        out_ready_i = 1'b0;
        send(20, 1'b1);
        send(21, 1'b1);
        in_valid_i = 1'b1; in_data_i = mk_data(22); in_ctrl_i = mk_ctrl(22);
        @(negedge clk);
        chk("bp_in_ready_full", 128'(in_ready_o), 128'(0));
        chk("bp_hold_data",     128'(out_data_o), 128'(mk_data(20)));
        @(posedge clk); #1;
        chk("bp_hold_data2",    128'(out_data_o), 128'(mk_data(20)));
        chk("bp_hold_ctrl",     128'(out_ctrl_o), 128'(mk_ctrl(20)));
        out_ready_i = 1'b1;
        send(22, 1'b0);
        idle(3);

        // Flush with both entries held; D offered but not accepted
        out_ready_i = 1'b0;
        send(30, 1'b1);
        send(31, 1'b1);
        in_valid_i = 1'b1; in_data_i = mk_data(32); in_ctrl_i = mk_ctrl(32); flush_i = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk("flush_in_ready_full", 128'(in_ready_o), 128'(0));
        @(posedge clk); #1;
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk("flush_out_valid", 128'(out_valid_o), 128'(0));
        chk("flush_in_ready",  128'(in_ready_o),  128'(1));
        chk("flush_out_null",  128'(out_null_o),  128'(1));
        chk("flush_out_ctrl",  128'(out_ctrl_o),  128'(0));
        out_ready_i = 1'b1;
        idle(3);

        // Flush while an incoming entry fires: accepted and discarded
        out_ready_i = 1'b0;
        send(40, 1'b1);
        in_valid_i = 1'b1; in_data_i = mk_data(41); in_ctrl_i = mk_ctrl(41); flush_i = 1'b1;
        @(negedge clk);
        exp_q.delete();
        chk("flush2_in_ready", 128'(in_ready_o), 128'(1));
        @(posedge clk); #1;
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk("flush2_out_valid", 128'(out_valid_o), 128'(0));
        chk("flush2_in_ready_after", 128'(in_ready_o), 128'(1));
        out_ready_i = 1'b1;
        idle(3);

        // Bubble gating: all-ones control offered without valid
        in_ctrl_i = 16'hFFFF; in_data_i = mk_data(77);
        idle(2);
        chk("bubble_ctrl_gated", 128'(out_ctrl_o), 128'(0));
        chk("bubble_null",       128'(out_null_o), 128'(1));

        // Asynchronous reset mid-transfer
        out_ready_i = 1'b0;
        send(50, 1'b1);
        send(51, 1'b1);
        in_valid_i = 1'b1; in_data_i = mk_data(52); in_ctrl_i = mk_ctrl(52);
        #2;
        rst_i = 1'b1;
        #1;
        exp_q.delete();
        chk("arst_out_valid", 128'(out_valid_o), 128'(0));
        chk("arst_out_null",  128'(out_null_o),  128'(1));
        chk("arst_out_ctrl",  128'(out_ctrl_o),  128'(0));
        chk("arst_in_ready",  128'(in_ready_o),  128'(1));
        chk("arst_out_data",  128'(out_data_o),  128'(0));
        @(negedge clk);
        rst_i = 1'b0; in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        idle(3);

`ifdef PIPE_STAGE_PERF_EN
        // Perf counters: 2 idle cycles, one accept (bubble), 3 stalled cycles
        out_ready_i = 1'b0;
        #1 rst_i = 1'b1;
        #1 exp_q.delete();
        @(negedge clk);
        rst_i = 1'b0;
        idle(2);
        send(60, 1'b1);
        in_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("perf_stall_cnt", 128'(stall_cnt_o), 128'(3));
        chk("perf_bubble_ge2", 128'(bubble_cnt_o >= 32'd2), 128'(1));
        out_ready_i = 1'b1;
        idle(3);
`endif

        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
